// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared constants and FSM state type for cpu_mem_server
package cpu_mem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port RAM, sync write, write-first registered read
module mem_array #(
    parameter int WORD_W = cpu_mem_pkg::WORD_W,
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents are deliberately not reset; only the read register is.
    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/cpu_mem_server.sv
// rtl/cpu_mem_server.sv - program loader plus instruction/data memory server for a CPU
module cpu_mem_server #(
    parameter int WORD_W = cpu_mem_pkg::WORD_W,
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read_write_memory,
    input  logic [WORD_W-1:0] data_out_memory,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] data_in_memory,
    output logic              enable,
    output logic              halted,
    output logic [ADDR_W:0]   prog_len,
    output logic [15:0]       run_cycles
);
    import cpu_mem_pkg::state_t, cpu_mem_pkg::ST_IDLE, cpu_mem_pkg::ST_LOAD,
           cpu_mem_pkg::ST_READY, cpu_mem_pkg::ST_RUN, cpu_mem_pkg::ST_HALT;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;
    logic              in_run;
    logic              halt_cond;
    logic [ADDR_W-1:0] imem_addr;

    assign load_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign accept     = load_valid && load_ready;
    assign in_run     = (state == ST_RUN);
    assign enable     = in_run;
    assign halted     = (state == ST_HALT);
    assign halt_cond  = ({1'b0, PC} >= prog_len);
    // The loader and the fetch path never overlap in time, so imem shares one port.
    assign imem_addr  = in_run ? PC : wr_ptr;

    mem_array #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_imem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rst_n && accept),
        .re    (in_run),
        .addr  (imem_addr),
        .wdata (load_data),
        .rdata (inst)
    );

    mem_array #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rst_n && in_run && read_write_memory),
        .re    (in_run),
        .addr  (addr),
        .wdata (data_out_memory),
        .rdata (data_in_memory)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            prog_len   <= '0;
            run_cycles <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        prog_len <= prog_len + 1'b1;
                        state    <= (load_last || (&wr_ptr)) ? ST_READY : ST_LOAD;
                    end
                end
                ST_READY, ST_HALT: begin
                    if (start) begin
                        state      <= ST_RUN;
                        run_cycles <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (halt_cond) begin
                        state <= ST_HALT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_server.sv
// tb/tb_cpu_mem_server.sv - directed self-checking bench for cpu_mem_server
module tb_cpu_mem_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        start;
    logic [7:0]  PC;
    logic [7:0]  addr;
    logic        read_write_memory;
    logic [15:0] data_out_memory;
    logic [15:0] inst;
    logic [15:0] data_in_memory;
    logic        enable;
    logic        halted;
    logic [8:0]  prog_len;
    logic [15:0] run_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_mem_server dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_valid        (load_valid),
        .load_data         (load_data),
        .load_last         (load_last),
        .load_ready        (load_ready),
        .start             (start),
        .PC                (PC),
        .addr              (addr),
        .read_write_memory (read_write_memory),
        .data_out_memory   (data_out_memory),
        .inst              (inst),
        .data_in_memory    (data_in_memory),
        .enable            (enable),
        .halted            (halted),
        .prog_len          (prog_len),
        .run_cycles        (run_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_enable"},     32'(enable),     32'd0);
        check({tag, "_halted"},     32'(halted),     32'd0);
        check({tag, "_prog_len"},   32'(prog_len),   32'd0);
        check({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
        check({tag, "_inst"},       32'(inst),       32'd0);
        check({tag, "_data_in"},    32'(data_in_memory), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; PC = '0; addr = '0; read_write_memory = 1'b0; data_out_memory = '0;
        tick(); tick();
        rst_n = 1'b1;
        check_reset_outputs("por");

        // start in IDLE must be ignored
        start = 1'b1; tick(); start = 1'b0;
        check("idle_start_enable", 32'(enable), 32'd0);
        check("idle_start_ready",  32'(load_ready), 32'd1);

        load_word(16'h0401, 1'b0);
        check("load1_prog_len", 32'(prog_len), 32'd1);
        check("load1_ready",    32'(load_ready), 32'd1);
        load_word(16'h0C01, 1'b0);
        load_word(16'h4000, 1'b1);
        check("load3_prog_len", 32'(prog_len), 32'd3);
        check("load3_ready",    32'(load_ready), 32'd0);
        check("load3_enable",   32'(enable), 32'd0);

        // load_valid outside IDLE/LOAD is dropped
        load_word(16'hDEAD, 1'b1);
        check("ready_extra_load", 32'(prog_len), 32'd3);

        PC = 8'd0; start = 1'b1; tick(); start = 1'b0;
        check("run_enable",     32'(enable), 32'd1);
        check("run_cycles0",    32'(run_cycles), 32'd0);
        tick();
        check("fetch_pc0", 32'(inst), 32'h0401);
        PC = 8'd1; tick();
        check("fetch_pc1", 32'(inst), 32'h0C01);
        PC = 8'd2; tick();
        check("fetch_pc2", 32'(inst), 32'h4000);
        check("run_cycles3", 32'(run_cycles), 32'd3);

        addr = 8'h10; read_write_memory = 1'b1; data_out_memory = 16'h1234; tick();
        read_write_memory = 1'b0; data_out_memory = 16'h0000; tick();
        check("dmem_read_1234", 32'(data_in_memory), 32'h1234);
        read_write_memory = 1'b1; data_out_memory = 16'hBEEF; tick();
        check("dmem_write_first", 32'(data_in_memory), 32'hBEEF);
        read_write_memory = 1'b0;

        // PC beyond the program: halt, with start ignored in the same cycle
        PC = 8'd3; start = 1'b1; tick(); start = 1'b0;
        check("halt_halted",  32'(halted), 32'd1);
        check("halt_enable",  32'(enable), 32'd0);
        check("halt_cycles",  32'(run_cycles), 32'd7);
        addr = 8'h10; read_write_memory = 1'b1; data_out_memory = 16'h5555; tick();
        read_write_memory = 1'b0;
        check("halt_cycles_frozen", 32'(run_cycles), 32'd7);
        check("halt_data_hold",     32'(data_in_memory), 32'hBEEF);

        PC = 8'd0; start = 1'b1; tick(); start = 1'b0;
        check("restart_enable", 32'(enable), 32'd1);
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_cycles", 32'(run_cycles), 32'd0);
        tick();
        check("dmem_preserved", 32'(data_in_memory), 32'hBEEF);
        check("restart_fetch",  32'(inst), 32'h0401);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_reset_outputs("rst_run1");

        for (int i = 0; i < 255; i++) begin
            load_word(16'h5A00 + 16'(i), 1'b0);
        end
        check("full255_prog_len", 32'(prog_len), 32'd255);
        check("full255_ready",    32'(load_ready), 32'd1);
        load_word(16'h5AFF, 1'b0);
        check("full256_prog_len", 32'(prog_len), 32'd256);
        check("full256_ready",    32'(load_ready), 32'd0);
        load_word(16'hFFFF, 1'b0);
        check("full_extra_ignored", 32'(prog_len), 32'd256);

        PC = 8'd1; start = 1'b1; tick(); start = 1'b0;
        tick();
        check("full_fetch1", 32'(inst), 32'h5A01);
        PC = 8'd255; tick();
        check("full_fetch255", 32'(inst), 32'h5AFF);
        check("full_no_halt",  32'(enable), 32'd1);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_reset_outputs("rst_run2");

        load_word(16'h7777, 1'b1);
        check("reload_prog_len", 32'(prog_len), 32'd1);
        PC = 8'd0; start = 1'b1; tick(); start = 1'b0;
        tick();
        check("reload_fetch0", 32'(inst), 32'h7777);
        PC = 8'd1; tick();
        check("retained_fetch1", 32'(inst), 32'h5A01);
        check("reload_halted",   32'(halted), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
